// File: rtl/qspi_sync_slave.sv
// QSPI slave sampled entirely in the CLK domain: pins are synchronised, edges are
// detected, and words are received on DQ[0] (single) or DQ[3:0] (quad), sent on DQ[1].
module qspi_sync_slave #(
    parameter int G_WORD_SIZE   = 8,
    parameter int G_SYNC_STAGES = 2
) (
    input  logic                   CLK,
    input  logic                   RESETN,
    input  logic                   QUAD_MODE,
    input  logic [G_WORD_SIZE-1:0] DATA_IN,
    input  logic                   DI_VALID,
    output logic                   SPI_BUSY,
    output logic [G_WORD_SIZE-1:0] DATA_OUT,
    output logic                   DO_VALID,
    output logic                   FRAME_ERR,
    input  logic                   SPI_CLK,
    input  logic                   CE,
    inout  wire  [3:0]             DQ
);

    localparam int W     = G_WORD_SIZE;
    localparam int S     = G_SYNC_STAGES;
    localparam int CNT_W = $clog2(W + 1);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t state, state_next;

    logic [S-1:0]      sclk_sync, ce_sync, fill;
    logic [S-1:0][3:0] dq_sync;
    logic              sclk_s, ce_s;
    logic [3:0]        dq_s;

    logic              sclk_prev, ce_prev;
    logic              sclk_rise, sclk_fall, ce_rise, ce_fall;
    logic [3:0]        dq_q;
    logic              armed;

    logic              quad_lat;
    logic [W-1:0]      rx_shift, rx_shift_next;
    logic [CNT_W-1:0]  rx_cnt, rx_step, cnt_sum, cnt_after;
    logic              word_done;

    logic [W-1:0]      tx_reg;
    logic [CNT_W-1:0]  tx_left;

    logic              start, frame_end, rx_edge, tx_edge, load_ok, dq1_oe, dq1_val;

    // CE idles high, so its synchroniser resets to 1 to avoid a false frame start.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sclk_sync <= '0;
            ce_sync   <= '1;
            dq_sync   <= '0;
            fill      <= '0;
        end else begin
            sclk_sync <= {sclk_sync[S-2:0], SPI_CLK};
            ce_sync   <= {ce_sync[S-2:0], CE};
            dq_sync   <= {dq_sync[S-2:0], DQ};
            fill      <= {fill[S-2:0], 1'b1};
        end
    end

    assign sclk_s = sclk_sync[S-1];
    assign ce_s   = ce_sync[S-1];
    assign dq_s   = dq_sync[S-1];

    // Edge flags are registered; dq_q stays aligned with sclk_rise.
    // armed only sets once the synchroniser holds real pin samples showing CE high,
    // so a frame already in progress at reset release is ignored.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sclk_prev <= 1'b0;
            ce_prev   <= 1'b1;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            ce_rise   <= 1'b0;
            ce_fall   <= 1'b0;
            dq_q      <= '0;
            armed     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flag sees the previous-cycle sclk_prev/ce_prev.
            sclk_prev <= sclk_s;
            ce_prev   <= ce_s;
            sclk_rise <= sclk_s & ~sclk_prev;
            sclk_fall <= ~sclk_s & sclk_prev;
            ce_rise   <= ce_s & ~ce_prev;
            ce_fall   <= ~ce_s & ce_prev;
            dq_q      <= dq_s;
            armed     <= armed | (fill[S-1] & ce_s);
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (ce_fall && armed) state_next = S_SHIFT;
            S_SHIFT: if (ce_rise)          state_next = S_IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        start     = 1'b0;
        frame_end = 1'b0;
        rx_edge   = 1'b0;
        tx_edge   = 1'b0;
        load_ok   = 1'b0;
        dq1_oe    = 1'b0;
        unique case (state)
            S_IDLE: begin
                start   = ce_fall && armed;
                load_ok = DI_VALID && !SPI_BUSY;
            end
            S_SHIFT: begin
                frame_end = ce_rise;
                rx_edge   = sclk_rise;
                tx_edge   = sclk_fall && !quad_lat;
                dq1_oe    = !ce_s && !quad_lat;
            end
        endcase
    end

    assign rx_step       = quad_lat ? CNT_W'(4) : CNT_W'(1);
    assign rx_shift_next = quad_lat ? ((rx_shift << 4) | W'(dq_q)) : ((rx_shift << 1) | W'(dq_q[0]));
    assign cnt_sum       = rx_cnt + rx_step;
    assign word_done     = rx_edge && (cnt_sum == CNT_W'(W));
    // The data bit is folded in before a coincident frame end is judged.
    assign cnt_after     = rx_edge ? (word_done ? '0 : cnt_sum) : rx_cnt;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            quad_lat  <= 1'b0;
            rx_shift  <= '0;
            rx_cnt    <= '0;
            DATA_OUT  <= '0;
            DO_VALID  <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            DO_VALID  <= 1'b0;
            FRAME_ERR <= 1'b0;
            if (rx_edge) rx_shift <= rx_shift_next;
            if (word_done) begin
                DATA_OUT <= rx_shift_next;
                DO_VALID <= 1'b1;
            end
            rx_cnt <= cnt_after;
            if (frame_end) begin
                rx_cnt    <= '0;
                FRAME_ERR <= (cnt_after != '0);
            end
            if (start) begin
                quad_lat <= QUAD_MODE;
                rx_cnt   <= '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            tx_reg   <= '0;
            tx_left  <= '0;
            SPI_BUSY <= 1'b0;
        end else if (load_ok) begin
            tx_reg   <= DATA_IN;
            tx_left  <= CNT_W'(W);
            SPI_BUSY <= 1'b1;
        end else if (frame_end) begin
            tx_left  <= '0;
            SPI_BUSY <= 1'b0;
        end else if (tx_edge && tx_left != '0) begin
            tx_reg  <= tx_reg << 1;
            tx_left <= tx_left - CNT_W'(1);
            if (tx_left == CNT_W'(1)) SPI_BUSY <= 1'b0;
        end
    end

    assign dq1_val = (tx_left != '0) ? tx_reg[W-1] : 1'b0;

    assign DQ[0] = 1'bz;
    assign DQ[1] = dq1_oe ? dq1_val : 1'bz;
    assign DQ[2] = 1'bz;
    assign DQ[3] = 1'bz;

endmodule

// File: tb/tb_qspi_sync_slave.sv
// Directed bench for qspi_sync_slave: single/quad receive, transmit, abort,
// coincident CE/SPI_CLK edges and mid-frame reset. DQ[1] has a pull-up so high-Z reads 1.
module tb_qspi_sync_slave;

    localparam int HALF = 250;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       quad_mode = 1'b0;
    logic [7:0] data_in = '0;
    logic       di_valid = 1'b0;
    logic       spi_busy;
    logic [7:0] data_out;
    logic       do_valid;
    logic       frame_err;
    logic       spi_clk = 1'b0;
    logic       ce = 1'b1;
    wire  [3:0] dq;

    logic [3:0] dq_val = '0;
    logic [3:0] dq_en = 4'b0001;
    logic [7:0] tx_smp = '0;
    logic       smp;

    int n_checks = 0;
    int n_fail = 0;
    int dv_cnt = 0;
    int fe_cnt = 0;
    int dv0, fe0;
    logic [7:0] dv_q[$];

    assign dq[0] = dq_en[0] ? dq_val[0] : 1'bz;
    assign dq[1] = dq_en[1] ? dq_val[1] : 1'bz;
    assign dq[2] = dq_en[2] ? dq_val[2] : 1'bz;
    assign dq[3] = dq_en[3] ? dq_val[3] : 1'bz;
    pullup pu_dq1 (dq[1]);

    qspi_sync_slave #(.G_WORD_SIZE(8), .G_SYNC_STAGES(2)) dut (
        .CLK(clk), .RESETN(resetn), .QUAD_MODE(quad_mode), .DATA_IN(data_in),
        .DI_VALID(di_valid), .SPI_BUSY(spi_busy), .DATA_OUT(data_out),
        .DO_VALID(do_valid), .FRAME_ERR(frame_err), .SPI_CLK(spi_clk), .CE(ce), .DQ(dq)
    );

    always #20 clk = ~clk;

    always @(negedge clk) begin
        if (do_valid) begin
            dv_cnt++;
            dv_q.push_back(data_out);
        end
        if (frame_err) fe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_cycle(input logic [3:0] nib, output logic s);
        dq_val = nib;
        #HALF;
        s = dq[1];
        spi_clk = 1'b1;
        #HALF;
        spi_clk = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] w, input int n);
        logic s;
        for (int i = 0; i < n; i++) begin
            spi_cycle({3'b000, w[7-i]}, s);
            tx_smp[7-i] = s;
        end
    endtask

    task automatic ce_low();
        ce = 1'b0;
        #HALF;
    endtask

    task automatic ce_high();
        #HALF;
        ce = 1'b1;
        #(2*HALF);
    endtask

    task automatic load_word(input logic [7:0] w);
        @(negedge clk);
        data_in  = w;
        di_valid = 1'b1;
        @(negedge clk);
        di_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_clks(5);
        check("rst_data_out", data_out, 8'h00);
        check("rst_do_valid", do_valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_busy", spi_busy, 1'b0);
        check("rst_dq1_hiz", dq[1], 1'b1);
        resetn = 1'b1;
        wait_clks(10);

        // Single-mode receive of 0x85
        dv0 = dv_cnt; fe0 = fe_cnt;
        ce_low();
        send_bits(8'h85, 8);
        ce_high();
        check("single_dv_count", dv_cnt - dv0, 1);
        check("single_data", data_out, 8'h85);
        check("single_no_ferr", fe_cnt - fe0, 0);

        // Back-to-back words under one CE
        dv0 = dv_cnt;
        ce_low();
        send_bits(8'h85, 8);
        send_bits(8'hA1, 8);
        ce_high();
        check("b2b_dv_count", dv_cnt - dv0, 2);
        check("b2b_word0", dv_q[dv0], 8'h85);
        check("b2b_word1", dv_q[dv0+1], 8'hA1);

        // Transmit 0x3C while receiving 0x5A
        load_word(8'h3C);
        check("tx_busy_next_cycle", spi_busy, 1'b1);
        ce_low();
        send_bits(8'h5A, 7);
        wait_clks(6);
        check("tx_busy_after_7_falls", spi_busy, 1'b1);
        spi_cycle(4'b0000, smp);
        tx_smp[0] = smp;
        wait_clks(6);
        check("tx_busy_after_8_falls", spi_busy, 1'b0);
        check("tx_bits_on_dq1", tx_smp, 8'h3C);
        check("tx_dq1_zero_when_done", dq[1], 1'b0);
        ce_high();
        check("tx_rx_data", data_out, 8'h5A);

        // Quad receive 0xA,0x1 with a word loaded (held for the whole frame)
        load_word(8'h55);
        quad_mode = 1'b1;
        dv0 = dv_cnt;
        ce_low();
        check("quad_dq1_hiz_start", dq[1], 1'b1);
        dq_en = 4'b1111;
        spi_cycle(4'hA, smp);
        check("quad_no_dv_after_1st", dv_cnt - dv0, 0);
        spi_cycle(4'h1, smp);
        check("quad_dv_after_2nd", dv_cnt - dv0, 1);
        check("quad_data", data_out, 8'hA1);
        dq_en = 4'b0001;
        wait_clks(2);
        check("quad_dq1_hiz_end", dq[1], 1'b1);
        check("quad_busy_held", spi_busy, 1'b1);
        ce_high();
        check("quad_busy_clr_on_ce", spi_busy, 1'b0);
        quad_mode = 1'b0;

        // Frame abort after 5 bits, then a full 0xFF frame
        dv0 = dv_cnt; fe0 = fe_cnt;
        ce_low();
        send_bits(8'hFF, 5);
        ce_high();
        check("abort_ferr_count", fe_cnt - fe0, 1);
        check("abort_no_dv", dv_cnt - dv0, 0);
        check("abort_data_kept", data_out, 8'hA1);
        ce_low();
        send_bits(8'hFF, 8);
        ce_high();
        check("after_abort_data", data_out, 8'hFF);
        check("after_abort_ferr", fe_cnt - fe0, 1);

        // CE and SPI_CLK rise together on the word's last bit
        dv0 = dv_cnt; fe0 = fe_cnt;
        ce_low();
        send_bits(8'hC3, 7);
        dq_val = 4'b0001;
        #HALF;
        spi_clk = 1'b1;
        ce = 1'b1;
        #HALF;
        spi_clk = 1'b0;
        #(2*HALF);
        check("coincident_dv", dv_cnt - dv0, 1);
        check("coincident_data", data_out, 8'hC3);
        check("coincident_no_ferr", fe_cnt - fe0, 0);

        // Reset mid-frame after 3 bits
        load_word(8'h00);
        ce_low();
        send_bits(8'h85, 3);
        check("pre_rst_dq1_driven", dq[1], 1'b0);
        #7;
        resetn = 1'b0;
        #1;
        check("midrst_data_out", data_out, 8'h00);
        check("midrst_busy", spi_busy, 1'b0);
        check("midrst_do_valid", do_valid, 1'b0);
        check("midrst_frame_err", frame_err, 1'b0);
        check("midrst_dq1_hiz", dq[1], 1'b1);
        wait_clks(3);
        resetn = 1'b1;
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_bits(8'h96, 8);
        ce_high();
        check("postrst_no_dv", dv_cnt - dv0, 0);
        check("postrst_no_ferr", fe_cnt - fe0, 0);
        check("postrst_data_zero", data_out, 8'h00);
        ce_low();
        send_bits(8'h85, 8);
        ce_high();
        check("postrst_new_frame_dv", dv_cnt - dv0, 1);
        check("postrst_new_frame_data", data_out, 8'h85);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qspi_sync_slave.md
QSPI_SYNC_SLAVE -- requirements
Module: qspi_sync_slave

Interface
Parameters:
REQ-001 SHALL provide parameter G_WORD_SIZE, default 8, bits per word; a multiple of 4, minimum 4.
REQ-002 SHALL provide parameter G_SYNC_STAGES, default 2, flip-flop stages on each of SPI_CLK, CE and DQ[3:0]; minimum 2.

Ports:
REQ-003 SHALL have port CLK, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port RESETN, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port QUAD_MODE, input, 1, 0 = single-bit mode, 1 = quad mode; sampled only in IDLE.
REQ-006 SHALL have port DATA_IN, input, G_WORD_SIZE, response word to shift out in single mode.
REQ-007 SHALL have port DI_VALID, input, 1, DATA_IN is valid.
REQ-008 SHALL have port SPI_BUSY, output, 1, response word accepted and not yet fully shifted out.
REQ-009 SHALL have port DATA_OUT, output, G_WORD_SIZE, last received word.
REQ-010 SHALL have port DO_VALID, output, 1, one-cycle strobe: DATA_OUT updated.
REQ-011 SHALL have port FRAME_ERR, output, 1, one-cycle strobe: frame ended on a partial word.
REQ-012 SHALL have port SPI_CLK, input, 1, SPI clock from the master; idles low (mode 0).
REQ-013 SHALL have port CE, input, 1, active-low chip enable.
REQ-014 SHALL have port DQ, inout, 4, data lines; only DQ[1] is ever driven by this block.

Function
REQ-015 SHALL pass SPI_CLK, CE and DQ through G_SYNC_STAGES synchronisers, then detect edges on the synchronised SPI_CLK and CE.
- Edges are seen G_SYNC_STAGES+1 CLK cycles after the pin change.
REQ-016 SHALL operate correctly when every SPI_CLK and CE level lasts at least 2 CLK cycles (SPI_CLK <= CLK/4).
REQ-017 SHALL implement the FSM IDLE -> SHIFT on a CE falling edge, and SHIFT -> IDLE on a CE rising edge.
- QUAD_MODE is latched on the IDLE -> SHIFT transition.
REQ-018 SHALL, in SHIFT with single mode, shift synchronised DQ[0] into the receive register on each SPI_CLK rising edge, MSB first.
REQ-019 SHALL, in SHIFT with quad mode, shift synchronised DQ[3:0] in on each SPI_CLK rising edge.
- Most significant nibble first; DQ[3] is the nibble MSB.
REQ-020 SHALL count received bits (+1 per edge in single mode, +4 in quad mode).
- On reaching G_WORD_SIZE: copy the word to DATA_OUT, pulse DO_VALID for exactly 1 cycle, clear the counter.
- DO_VALID follows the completing edge detect by 1 cycle.
REQ-021 SHALL receive back-to-back words while CE stays low, with no gap required between words.
REQ-022 SHALL, on a CE rising edge with a nonzero bit count, pulse FRAME_ERR for 1 cycle, discard the partial word and leave DATA_OUT unchanged.
REQ-023 SHALL accept DATA_IN when DI_VALID = 1, SPI_BUSY = 0 and the FSM is in IDLE.
- SPI_BUSY rises on the following cycle.
- DI_VALID is ignored while SPI_BUSY = 1 or the FSM is in SHIFT.
REQ-024 SHALL drive DQ[1] only while synchronised CE = 0 and the latched mode is single; otherwise DQ[1] SHALL be high-Z.
- DQ[0], DQ[2] and DQ[3] SHALL always be high-Z.
REQ-025 SHALL present the transmit MSB on DQ[1] on the cycle after the CE falling edge detect.
- Each subsequent bit follows each SPI_CLK falling edge detect.
- DQ[1] drives 0 when no word is loaded or all bits are sent.
REQ-026 SHALL clear SPI_BUSY 1 cycle after the falling edge that follows the last transmitted bit, or on a CE rising edge, whichever comes first.
REQ-027 SHALL, when a CE rising and an SPI_CLK rising edge are detected in the same cycle, process the data bit first and then the frame end.
- If that bit completes the word: DO_VALID pulses and FRAME_ERR does not.
REQ-028 SHALL hold the transmit word for the whole frame in quad mode, leaving SPI_BUSY = 1 until CE rises.

Reset
REQ-029 SHALL, while RESETN = 0, asynchronously force:
- FSM to IDLE; counters, shift registers and synchronisers to 0 (CE synchroniser to 1);
- DATA_OUT = 0, DO_VALID = 0, FRAME_ERR = 0, SPI_BUSY = 0;
- DQ all high-Z.
REQ-030 SHALL, after RESETN deasserts mid-frame, ignore the current frame until CE has been seen high and then low again.

Verification (CLK 25 MHz, SPI_CLK 2 MHz, G_WORD_SIZE 8)
REQ-031 SHALL verify single-mode receive: CE low, DQ[0] sends 0x85 MSB first -> exactly one DO_VALID, DATA_OUT = 0x85, FRAME_ERR stays 0.
REQ-032 SHALL verify back-to-back words: 0x85 then 0xA1 with CE held low -> two DO_VALID pulses, DATA_OUT 0x85 then 0xA1.
REQ-033 SHALL verify quad-mode receive: QUAD_MODE = 1, nibbles 0xA, 0x1 -> DO_VALID after the 2nd rising edge, DATA_OUT = 0xA1, DQ[1] high-Z throughout.
REQ-034 SHALL verify transmit: DATA_IN = 0x3C, DI_VALID pulsed in IDLE -> SPI_BUSY = 1 the next cycle.
- DQ[1] sampled on SPI_CLK rising edges = 0,0,1,1,1,1,0,0.
- SPI_BUSY = 0 after the 8th falling edge.
REQ-035 SHALL verify frame abort: CE rises after 5 bits -> one FRAME_ERR pulse, no DO_VALID, DATA_OUT unchanged; the next full frame of 0xFF yields DATA_OUT = 0xFF.
REQ-036 SHALL verify reset mid-frame: RESETN = 0 after 3 bits -> all outputs 0 and DQ high-Z in the same cycle; after release, no DO_VALID until a new CE falling edge.
